// File: rtl/wave_capture_trigger_if.sv
// rtl/wave_capture_trigger_if.sv - readout stream bundle for the capture buffer
interface wave_capture_trigger_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  // Producer side: the capture buffer streaming its window out
  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  // Consumer side: UART bridge / host reader
  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/wave_capture_trigger.sv
// rtl/wave_capture_trigger.sv - triggered circular capture of the DAC stream with oldest-first readout
module wave_capture_trigger #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      sample_in,
  input  logic                   sample_valid,
  input  logic                   arm,
  input  logic [DATA_W-1:0]      trig_level,
  input  logic                   trig_edge,
  input  logic                   force_trig,
  input  logic [ADDR_W-1:0]      pre_count,
  input  logic                   rd_start,
  wave_capture_trigger_if.master rd,
  output logic                   armed,
  output logic                   triggered,
  output logic                   done,
  output logic [ADDR_W-1:0]      trig_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE,
    S_READ
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              prev_vld_q;
  logic              force_pend_q;
  logic              armed_q;
  logic              triggered_q;
  logic              done_q;
  logic              rd_valid_q;
  logic              rd_last_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] post_w;
  logic [ADDR_W-1:0] cnt_inc;
  logic              capturing;
  logic              wr_en;
  logic              hit_rise;
  logic              hit_fall;
  logic              trig_now;
  logic              fetch;
  logic              xfer_last;

  // pre_count is ADDR_W wide so it can never exceed DEPTH-1; post fills the rest of the window
  assign post_w  = {ADDR_W{1'b1}} - pre_q;
  assign cnt_inc = cnt_q + ADDR_W'(1);

  // A new arm owns the cycle it arrives in, so that sample is not written
  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign wr_en     = capturing && sample_valid && !arm;

  assign hit_rise = prev_vld_q && (prev_q <  trig_level) && (sample_in >= trig_level);
  assign hit_fall = prev_vld_q && (prev_q >= trig_level) && (sample_in <  trig_level);
  assign trig_now = (state_q == S_WAIT) && wr_en &&
                    ((trig_edge ? hit_fall : hit_rise) || force_trig || force_pend_q);

  // Refill the output register whenever it is empty or being drained, until the last beat is loaded
  assign fetch     = (state_q == S_READ) && (!rd_valid_q || rd.rd_ready) && !(rd_valid_q && rd_last_q);
  assign xfer_last = (state_q == S_READ) && rd_valid_q && rd_last_q && rd.rd_ready;

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign armed       = armed_q;
  assign triggered   = triggered_q;
  assign done        = done_q;
  assign trig_addr   = trig_addr_q;

  // Sample RAM write port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

  // Capture/readout sequencer with registered status and stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      trig_addr_q  <= '0;
      prev_q       <= '0;
      rd_data_q    <= '0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
      armed_q      <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q   <= wr_ptr_q + ADDR_W'(1);
        prev_q     <= sample_in;
        prev_vld_q <= 1'b1;
      end

      if (arm && (state_q != S_READ)) begin
        pre_q        <= pre_count;
        cnt_q        <= '0;
        wr_ptr_q     <= '0;
        triggered_q  <= 1'b0;
        prev_vld_q   <= 1'b0;
        force_pend_q <= 1'b0;
        armed_q      <= 1'b1;
        done_q       <= 1'b0;
        state_q      <= (pre_count == '0) ? S_WAIT : S_PRE;
      end else begin
        case (state_q)
          S_PRE: begin
            if (wr_en) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == pre_q) begin
                cnt_q   <= '0;
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (trig_now) begin
              trig_addr_q  <= wr_ptr_q;
              triggered_q  <= 1'b1;
              force_pend_q <= 1'b0;
              cnt_q        <= '0;
              if (post_w == '0) begin
                armed_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_POST;
              end
            end else if (force_trig) begin
              force_pend_q <= 1'b1;
            end
          end
          S_POST: begin
            if (wr_en) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == post_w) begin
                armed_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
          S_DONE: begin
            if (rd_start) begin
              rd_ptr_q <= trig_addr_q - pre_q;
              cnt_q    <= '0;
              state_q  <= S_READ;
            end
          end
          S_READ: begin
            if (fetch) begin
              rd_data_q  <= mem[rd_ptr_q];
              rd_valid_q <= 1'b1;
              rd_last_q  <= (cnt_q == {ADDR_W{1'b1}});
              rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
              cnt_q      <= cnt_inc;
            end else if (xfer_last) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              done_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
